// File: rtl/cia_pipe_adder_if.sv
// ============================================================================
// Module   : cia_pipe_adder_if
// Brief    : Input/output valid-ready bus for the pipelined carry-increment adder.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface cia_pipe_adder_if #(
  parameter int N = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

`default_nettype wire

// File: rtl/cia_pipe_adder.sv
// ============================================================================
// Module   : cia_pipe_adder
// Brief    : Two-stage carry-increment adder: group sums, then gray-cell carry.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cia_pipe_adder #(
  parameter int N = 16,
  parameter int V = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  cia_pipe_adder_if.slave   bus
);
  localparam int M = N / V;

  generate
    if (((N % V) != 0) || (V < 2)) begin : g_param_check
      $error("cia_pipe_adder: N must be a multiple of V and V must be >= 2");
    end
  endgenerate

  logic         s1_valid_q, s1_valid_d;
  logic [N-1:0] s0_q, s0_d;
  logic [M-1:0] g_q, g_d;
  logic [M-1:0] p_q, p_d;
  logic         cin_q, cin_d;
  logic         out_valid_q, out_valid_d;
  logic [N-1:0] sum_q, sum_d;
  logic         cout_q, cout_d;

  logic         w_s2_free;
  logic         w_s2_adv;
  logic         w_in_ready;
  logic         w_in_fire;
  logic [N-1:0] w_s0;
  logic [M-1:0] w_g;
  logic [M-1:0] w_p;
  logic [N-1:0] w_sum;
  logic         w_cout;

  // Per-group local add with carry-in 0; the extra MSB is the group generate.
  generate
    for (genvar k = 0; k < M; k++) begin : g_group
      logic [V:0] w_add;
      assign w_add            = {1'b0, bus.a[k*V +: V]} + {1'b0, bus.b[k*V +: V]};
      assign w_s0[k*V +: V]   = w_add[V-1:0];
      assign w_g[k]           = w_add[V];
      assign w_p[k]           = &(bus.a[k*V +: V] ^ bus.b[k*V +: V]);
    end
  endgenerate

  always_comb begin
    w_s2_free  = !out_valid_q | bus.out_ready;
    w_s2_adv   = s1_valid_q & w_s2_free;
    w_in_ready = !s1_valid_q | w_s2_free;
    w_in_fire  = bus.in_valid & w_in_ready;
  end

  always_comb begin
    s1_valid_d = w_in_fire | (s1_valid_q & !w_s2_adv);
    s0_d       = s0_q;
    g_d        = g_q;
    p_d        = p_q;
    cin_d      = cin_q;
    if (w_in_fire) begin
      s0_d  = w_s0;
      g_d   = w_g;
      p_d   = w_p;
      cin_d = bus.cin;
    end
  end

  // Ripple gray-cell chain; each group's local sum is bumped by its carry-in.
  always_comb begin : p_stage2
    logic carry;
    w_sum = '0;
    carry = cin_q;
    for (int k = 0; k < M; k++) begin
      w_sum[k*V +: V] = s0_q[k*V +: V] + {{(V-1){1'b0}}, carry};
      carry           = g_q[k] | (p_q[k] & carry);
    end
    w_cout = carry;
  end

  always_comb begin
    out_valid_d = w_s2_adv | (out_valid_q & !bus.out_ready);
    sum_d       = sum_q;
    cout_d      = cout_q;
    if (w_s2_adv) begin
      sum_d  = w_sum;
      cout_d = w_cout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s0_q        <= '0;
      g_q         <= '0;
      p_q         <= '0;
      cin_q       <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s0_q        <= s0_d;
      g_q         <= g_d;
      p_q         <= p_d;
      cin_q       <= cin_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_cia_pipe_adder.sv
// ============================================================================
// Module   : tb_cia_pipe_adder
// Brief    : Scoreboard bench for cia_pipe_adder at (16,4), (12,3) and (8,2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cia_pipe_adder;
  logic clk;
  logic rst_n;

  int n_tests;
  int n_fails;

  logic [16:0] q16[$];
  logic [16:0] q12[$];
  logic [16:0] q8[$];

  cia_pipe_adder_if #(.N(16)) if16 ();
  cia_pipe_adder_if #(.N(12)) if12 ();
  cia_pipe_adder_if #(.N(8))  if8 ();

  cia_pipe_adder #(.N(16), .V(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
  cia_pipe_adder #(.N(12), .V(3)) u_dut12 (.clk(clk), .rst_n(rst_n), .bus(if12));
  cia_pipe_adder #(.N(8),  .V(2)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive, settle, score handshakes, advance past the edge.
  task automatic step(input logic iv, input logic orr,
                      input logic [15:0] av, input logic [15:0] bv, input logic ci);
    logic [16:0] e;
    if16.in_valid = iv; if16.out_ready = orr; if16.a = av;        if16.b = bv;        if16.cin = ci;
    if12.in_valid = iv; if12.out_ready = orr; if12.a = av[11:0];  if12.b = bv[11:0];  if12.cin = ci;
    if8.in_valid  = iv; if8.out_ready  = orr; if8.a  = av[7:0];   if8.b  = bv[7:0];   if8.cin  = ci;
    #1;
    if (if16.out_valid && if16.out_ready) begin
      check_eq("out16_expected", 32'(q16.size() > 0), 32'd1);
      if (q16.size() > 0) begin
        e = q16.pop_front();
        check_eq("result16", {15'd0, if16.cout, if16.sum}, {15'd0, e});
      end
    end
    if (if12.out_valid && if12.out_ready) begin
      check_eq("out12_expected", 32'(q12.size() > 0), 32'd1);
      if (q12.size() > 0) begin
        e = q12.pop_front();
        check_eq("result12", {19'd0, if12.cout, if12.sum}, {15'd0, e});
      end
    end
    if (if8.out_valid && if8.out_ready) begin
      check_eq("out8_expected", 32'(q8.size() > 0), 32'd1);
      if (q8.size() > 0) begin
        e = q8.pop_front();
        check_eq("result8", {23'd0, if8.cout, if8.sum}, {15'd0, e});
      end
    end
    if (if16.in_valid && if16.in_ready)
      q16.push_back({1'b0, av} + {1'b0, bv} + {16'd0, ci});
    if (if12.in_valid && if12.in_ready)
      q12.push_back({5'd0, {1'b0, av[11:0]} + {1'b0, bv[11:0]} + {12'd0, ci}});
    if (if8.in_valid && if8.in_ready)
      q8.push_back({9'd0, {1'b0, av[7:0]} + {1'b0, bv[7:0]} + {8'd0, ci}});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((q16.size() + q12.size() + q8.size()) > 0 && budget < 30) begin
      step(1'b0, 1'b1, 16'h0, 16'h0, 1'b0);
      budget++;
    end
    check_eq("drain16_empty", 32'(q16.size()), 32'd0);
    check_eq("drain12_empty", 32'(q12.size()), 32'd0);
    check_eq("drain8_empty",  32'(q8.size()),  32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fails = 0;
    rst_n   = 1'b0;
    if16.in_valid = 1'b0; if16.out_ready = 1'b0; if16.a = '0; if16.b = '0; if16.cin = 1'b0;
    if12.in_valid = 1'b0; if12.out_ready = 1'b0; if12.a = '0; if12.b = '0; if12.cin = 1'b0;
    if8.in_valid  = 1'b0; if8.out_ready  = 1'b0; if8.a  = '0; if8.b  = '0; if8.cin  = 1'b0;
    #1;
    check_eq("rst_out_valid", {31'd0, if16.out_valid}, 32'd0);
    check_eq("rst_sum",       {16'd0, if16.sum},       32'd0);
    check_eq("rst_cout",      {31'd0, if16.cout},      32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_in_ready", {31'd0, if16.in_ready}, 32'd1);

    // Basic add and two-cycle latency.
    step(1'b1, 1'b1, 16'h1234, 16'h4321, 1'b0);
    check_eq("lat_not_yet", {31'd0, if16.out_valid}, 32'd0);
    step(1'b0, 1'b1, 16'h0, 16'h0, 1'b0);
    check_eq("lat_valid", {31'd0, if16.out_valid}, 32'd1);
    check_eq("basic_sum", {16'd0, if16.sum},       32'h5555);
    check_eq("basic_cout", {31'd0, if16.cout},     32'd0);
    drain();

    // Full-propagate chain and MSB overflow.
    step(1'b1, 1'b1, 16'hFFFF, 16'h0000, 1'b1);
    step(1'b1, 1'b1, 16'h8000, 16'h8000, 1'b0);
    check_eq("prop_sum",  {16'd0, if16.sum},  32'h0000);
    check_eq("prop_cout", {31'd0, if16.cout}, 32'd1);
    step(1'b0, 1'b1, 16'h0, 16'h0, 1'b0);
    check_eq("ovf_sum",  {16'd0, if16.sum},  32'h0000);
    check_eq("ovf_cout", {31'd0, if16.cout}, 32'd1);
    drain();

    // Back-to-back beats, one result per cycle.
    step(1'b1, 1'b1, 16'h0001, 16'h0001, 1'b0);
    check_eq("b2b_ready0", {31'd0, if16.in_ready}, 32'd1);
    step(1'b1, 1'b1, 16'h00FF, 16'h0001, 1'b0);
    check_eq("b2b_ready1", {31'd0, if16.in_ready}, 32'd1);
    check_eq("b2b_sum0",   {15'd0, if16.out_valid, if16.sum}, 32'h1_0002);
    step(1'b1, 1'b1, 16'h0FFF, 16'h0001, 1'b0);
    check_eq("b2b_ready2", {31'd0, if16.in_ready}, 32'd1);
    check_eq("b2b_sum1",   {15'd0, if16.out_valid, if16.sum}, 32'h1_0100);
    step(1'b0, 1'b1, 16'h0, 16'h0, 1'b0);
    check_eq("b2b_sum2",   {15'd0, if16.out_valid, if16.sum}, 32'h1_1000);
    drain();

    // Backpressure: two beats accepted, third stalls, first result holds.
    step(1'b1, 1'b0, 16'h1111, 16'h2222, 1'b0);
    step(1'b1, 1'b0, 16'hF0F0, 16'h0F10, 1'b0);
    check_eq("bp_in_ready_low", {31'd0, if16.in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 16'hABCD, 16'h1111, 1'b0);
      check_eq("bp_hold_sum", {15'd0, if16.out_valid, if16.sum}, 32'h1_3333);
      check_eq("bp_hold_cout", {31'd0, if16.cout}, 32'd0);
    end
    check_eq("bp_accepted", 32'(q16.size()), 32'd2);
    step(1'b1, 1'b1, 16'hABCD, 16'h1111, 1'b0);
    check_eq("bp_next_sum", {14'd0, if16.out_valid, if16.cout, if16.sum}, 32'h3_0000);
    drain();

    // Asynchronous reset with two beats in flight.
    step(1'b1, 1'b0, 16'h0102, 16'h0304, 1'b0);
    step(1'b1, 1'b0, 16'h0506, 16'h0708, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", {31'd0, if16.out_valid}, 32'd0);
    check_eq("arst_sum",       {16'd0, if16.sum},       32'd0);
    check_eq("arst_cout",      {31'd0, if16.cout},      32'd0);
    q16.delete(); q12.delete(); q8.delete();
    if16.in_valid = 1'b0; if12.in_valid = 1'b0; if8.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("arst_in_ready", {31'd0, if16.in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 16'h0, 16'h0, 1'b0);
      check_eq("arst_no_stale", {31'd0, if16.out_valid}, 32'd0);
    end

    // Random traffic with random stalls on all three widths.
    for (int i = 0; i < 10000; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           16'($urandom), 16'($urandom), 1'($urandom));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
